// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV32M multiply/divide unit.
// One request is taken through a valid/ready handshake. It is then computed
// over XLEN cycles with radix-2 shift-add (multiply) or restoring division.
// The result comes back as a one-cycle pulse together with the request tag.
// Divide-by-zero and signed overflow skip the iteration and finish at once.
module muldiv_iter #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_funct3,
  input  logic [XLEN-1:0]  i_op_a,
  input  logic [XLEN-1:0]  i_op_b,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_flush,
  output logic             o_valid,
  output logic [XLEN-1:0]  o_result,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_busy
);

  localparam int              CNT_W   = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONE     = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN:0]   ONE_W   = {{XLEN{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, next_state;

  // Latched request: op, sign fix-up flag and tag.
  logic [2:0]       funct3_q;
  logic             negate_q;
  logic [TAG_W-1:0] tag_q;

  // Iteration registers. Multiply: {acc_hi, acc_lo} is the partial product
  // with the multiplier shifting out of acc_lo. Divide: acc_hi is the partial
  // remainder and acc_lo shifts the dividend out and the quotient in.
  // addend is the multiplicand magnitude or the divisor magnitude.
  logic [XLEN-1:0]  acc_hi, acc_lo, addend;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             last_step;

  logic             req_a_signed, req_b_signed;
  logic             req_a_neg, req_b_neg;
  logic [XLEN-1:0]  req_a_mag, req_b_mag;
  logic             req_negate;
  logic             req_special;
  logic [XLEN-1:0]  req_special_val;

  logic [XLEN:0]    shift_div;
  logic [XLEN:0]    add_x, add_y, add_sum;
  logic             add_cin;
  logic [XLEN-1:0]  hi_nx, lo_nx;

  logic             lo_carry;
  logic [XLEN-1:0]  lo_neg, hi_neg, rem_neg;
  logic [XLEN-1:0]  fin_result;

  assign accept    = i_valid && (state == IDLE) && !i_flush;
  assign last_step = (cnt == CNT_W'(1));

  // Decode the incoming request: operand signedness, magnitudes, the result
  // sign fix-up and the cases that finish without iterating.
  always_comb begin
    req_a_signed    = 1'b0;
    req_b_signed    = 1'b0;
    req_negate      = 1'b0;
    req_special     = 1'b0;
    req_special_val = '0;
    if (i_funct3[2]) begin
      req_a_signed = ~i_funct3[0];
      req_b_signed = ~i_funct3[0];
    end else begin
      req_a_signed = (i_funct3[1:0] != 2'b11);
      req_b_signed = ~i_funct3[1];
    end
    req_a_neg = req_a_signed & i_op_a[XLEN-1];
    req_b_neg = req_b_signed & i_op_b[XLEN-1];
    req_a_mag = req_a_neg ? (~i_op_a + ONE) : i_op_a;
    req_b_mag = req_b_neg ? (~i_op_b + ONE) : i_op_b;
    if (i_funct3[2] && i_funct3[1]) begin
      req_negate = req_a_neg;
    end else begin
      req_negate = req_a_neg ^ req_b_neg;
    end
    if (i_funct3[2]) begin
      if (i_op_b == '0) begin
        req_special     = 1'b1;
        req_special_val = i_funct3[1] ? i_op_a : '1;
      end else if (!i_funct3[0] && (i_op_a == MIN_INT) && (i_op_b == '1)) begin
        req_special     = 1'b1;
        req_special_val = i_funct3[1] ? '0 : MIN_INT;
      end
    end
  end

  // One shared XLEN+1-bit adder performs a single shift-add or trial
  // subtraction per cycle, and yields the next iteration registers.
  always_comb begin
    shift_div = {acc_hi, acc_lo[XLEN-1]};
    if (funct3_q[2]) begin
      add_x   = shift_div;
      add_y   = ~{1'b0, addend};
      add_cin = 1'b1;
    end else begin
      add_x   = {1'b0, acc_hi};
      add_y   = {1'b0, addend};
      add_cin = 1'b0;
    end
    add_sum = add_x + add_y + {{XLEN{1'b0}}, add_cin};
    if (funct3_q[2]) begin
      if (!add_sum[XLEN]) begin
        hi_nx = add_sum[XLEN-1:0];
        lo_nx = {acc_lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nx = shift_div[XLEN-1:0];
        lo_nx = {acc_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      if (acc_lo[0]) begin
        hi_nx = add_sum[XLEN:1];
        lo_nx = {add_sum[0], acc_lo[XLEN-1:1]};
      end else begin
        hi_nx = {1'b0, acc_hi[XLEN-1:1]};
        lo_nx = {acc_hi[0], acc_lo[XLEN-1:1]};
      end
    end
  end

  // Final sign fix-up and result selection from the last iteration step.
  // The low-half negation carry propagates into the high half of a product.
  always_comb begin
    {lo_carry, lo_neg} = {1'b0, ~lo_nx} + ONE_W;
    hi_neg  = ~hi_nx + {{(XLEN-1){1'b0}}, lo_carry};
    rem_neg = ~hi_nx + ONE;
    case (funct3_q)
      3'b000:         fin_result = negate_q ? lo_neg  : lo_nx;
      3'b100, 3'b101: fin_result = negate_q ? lo_neg  : lo_nx;
      3'b110, 3'b111: fin_result = negate_q ? rem_neg : hi_nx;
      default:        fin_result = negate_q ? hi_neg  : hi_nx;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; flush returns to IDLE from anywhere and beats accept.
  always_comb begin
    next_state = state;
    if (i_flush) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) next_state = req_special ? DONE : CALC;
        CALC:    if (last_step) next_state = DONE;
        DONE:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Handshake and status outputs; a flush in DONE suppresses the pulse.
  always_comb begin
    o_ready = (state == IDLE);
    o_busy  = (state != IDLE);
    o_valid = (state == DONE) && !i_flush;
  end

  // Datapath: load on accept, iterate in CALC, capture the result on the way
  // into DONE so it holds until the next result is produced.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      funct3_q <= '0;
      negate_q <= 1'b0;
      tag_q    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      addend   <= '0;
      cnt      <= '0;
      o_result <= '0;
      o_tag    <= '0;
    end else if (accept) begin
      funct3_q <= i_funct3;
      negate_q <= req_negate;
      tag_q    <= i_tag;
      acc_hi   <= '0;
      cnt      <= CNT_W'(XLEN);
      if (i_funct3[2]) begin
        acc_lo <= req_a_mag;
        addend <= req_b_mag;
      end else begin
        acc_lo <= req_b_mag;
        addend <= req_a_mag;
      end
      if (req_special) begin
        o_result <= req_special_val;
        o_tag    <= i_tag;
      end
    end else if ((state == CALC) && !i_flush) begin
      acc_hi <= hi_nx;
      acc_lo <= lo_nx;
      cnt    <= cnt - CNT_W'(1);
      if (last_step) begin
        o_result <= fin_result;
        o_tag    <= tag_q;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: directed vector table plus flush, reset and streaming
// sequences for the iterative multiply/divide unit.
module tb_muldiv_iter;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [2:0]  i_funct3;
  logic [31:0] i_op_a;
  logic [31:0] i_op_b;
  logic [4:0]  i_tag;
  logic        i_flush;
  logic        o_valid;
  logic [31:0] o_result;
  logic [4:0]  o_tag;
  logic        o_busy;

  int tests_run;
  int tests_failed;

  typedef struct {
    string       name;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  tag;
    logic [31:0] exp_result;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  muldiv_iter #(.XLEN(32), .TAG_W(5)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_funct3 (i_funct3),
    .i_op_a   (i_op_a),
    .i_op_b   (i_op_b),
    .i_tag    (i_tag),
    .i_flush  (i_flush),
    .o_valid  (o_valid),
    .o_result (o_result),
    .o_tag    (o_tag),
    .o_busy   (o_busy)
  );

  // 10 ns clock.
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Hard time limit so a stuck design cannot hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic addVec(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag,
                        input logic [31:0] exp_r, input int exp_lat);
    vec_t v;
    v.name = name; v.funct3 = f3; v.op_a = a; v.op_b = b; v.tag = tag;
    v.exp_result = exp_r; v.exp_lat = exp_lat;
    vecs.push_back(v);
  endtask

  // Independent reference built on the simulator's own arithmetic.
  function automatic logic [31:0] golden(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, q;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (f3)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); r = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'd4: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin q = sa / sb; r = q[31:0]; end
      end
      3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin q = sa % sb; r = q[31:0]; end
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Issue one request from IDLE and follow it to its result pulse.
  // Inputs are scrambled while the op is in flight to show they are ignored.
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] tag,
                               output logic [31:0] res, output logic [4:0] tg,
                               output int lat, output logic seen,
                               output logic busy_first, output logic pulse_end,
                               output logic ready_end, output logic held);
    @(negedge i_clk);
    i_valid = 1'b1; i_funct3 = f3; i_op_a = a; i_op_b = b; i_tag = tag;
    @(posedge i_clk);
    #1;
    i_valid  = 1'b0;
    i_funct3 = 3'($urandom);
    i_op_a   = $urandom;
    i_op_b   = $urandom;
    i_tag    = 5'($urandom);
    seen = 1'b0; lat = 0; res = '0; tg = '0;
    @(negedge i_clk);
    busy_first = o_busy;
    while (!seen && lat < 40) begin
      if (o_valid) begin
        seen = 1'b1;
        res  = o_result;
        tg   = o_tag;
      end else begin
        @(negedge i_clk);
        lat++;
      end
    end
    @(negedge i_clk);
    pulse_end = ~o_valid;
    ready_end = o_ready;
    held      = (o_result === res);
  endtask

  logic [31:0] r_res;
  logic [4:0]  r_tag;
  int          r_lat;
  logic        r_seen, r_busy, r_pulse, r_ready, r_held;
  int          stray;
  logic [2:0]  s_f3 [8];
  logic [31:0] s_a  [8];
  logic [31:0] s_b  [8];

  initial begin
    tests_run = 0; tests_failed = 0;
    i_rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0;
    i_funct3 = '0; i_op_a = '0; i_op_b = '0; i_tag = '0;

    addVec("mul_7xm3",     3'd0, 32'h0000_0007, 32'hFFFF_FFFD,  5'd3, 32'hFFFF_FFEB, 32);
    addVec("mulh_min",     3'd1, 32'h8000_0000, 32'h8000_0000,  5'd4, 32'h4000_0000, 32);
    addVec("mulhu_max",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  5'd5, 32'hFFFF_FFFE, 32);
    addVec("mulhsu_m1x2",  3'd2, 32'hFFFF_FFFF, 32'h0000_0002,  5'd6, 32'hFFFF_FFFF, 32);
    addVec("div_m7_2",     3'd4, 32'hFFFF_FFF9, 32'h0000_0002,  5'd7, 32'hFFFF_FFFD, 32);
    addVec("rem_m7_2",     3'd6, 32'hFFFF_FFF9, 32'h0000_0002,  5'd8, 32'hFFFF_FFFF, 32);
    addVec("divu_100_7",   3'd5, 32'd100,       32'd7,          5'd9, 32'd14,        32);
    addVec("remu_100_7",   3'd7, 32'd100,       32'd7,         5'd10, 32'd2,         32);
    addVec("div_by0",      3'd4, 32'd5,         32'd0,         5'd11, 32'hFFFF_FFFF,  0);
    addVec("rem_by0",      3'd6, 32'd5,         32'd0,         5'd12, 32'd5,          0);
    addVec("div_ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000,  0);
    addVec("rem_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0,          0);
    addVec("divu_by0",     3'd5, 32'hDEAD_BEEF, 32'd0,         5'd15, 32'hFFFF_FFFF,  0);
    addVec("remu_by0",     3'd7, 32'hDEAD_BEEF, 32'd0,         5'd16, 32'hDEAD_BEEF,  0);
    addVec("mul_m1xm1",    3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 32'd1,         32);
    addVec("mulh_m1xm1",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd18, 32'd0,         32);
    addVec("mulhu_min_2",  3'd3, 32'h8000_0000, 32'd2,         5'd19, 32'd1,         32);
    addVec("div_7_m2",     3'd4, 32'd7,         32'hFFFF_FFFE, 5'd20, 32'hFFFF_FFFD, 32);
    addVec("rem_7_m2",     3'd6, 32'd7,         32'hFFFF_FFFE, 5'd21, 32'd1,         32);
    addVec("divu_max_1",   3'd5, 32'hFFFF_FFFF, 32'd1,         5'd22, 32'hFFFF_FFFF, 32);
    addVec("mulh_m1x2",    3'd1, 32'hFFFF_FFFF, 32'd2,         5'd23, 32'hFFFF_FFFF, 32);
    addVec("mulhu_max_2",  3'd3, 32'hFFFF_FFFF, 32'd2,         5'd24, 32'd1,         32);

    // Reset state.
    #23;
    checkOutput("reset_ready",  32'(o_ready),  32'd1);
    checkOutput("reset_valid",  32'(o_valid),  32'd0);
    checkOutput("reset_busy",   32'(o_busy),   32'd0);
    checkOutput("reset_result", o_result,      32'd0);
    checkOutput("reset_tag",    32'(o_tag),    32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Directed vector table.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].funct3, vecs[i].op_a, vecs[i].op_b, vecs[i].tag,
                    r_res, r_tag, r_lat, r_seen, r_busy, r_pulse, r_ready, r_held);
      checkOutput({vecs[i].name, "_seen"},   32'(r_seen),  32'd1);
      checkOutput({vecs[i].name, "_result"}, r_res,        vecs[i].exp_result);
      checkOutput({vecs[i].name, "_tag"},    32'(r_tag),   32'(vecs[i].tag));
      checkOutput({vecs[i].name, "_lat"},    32'(r_lat),   32'(vecs[i].exp_lat));
      checkOutput({vecs[i].name, "_busy"},   32'(r_busy),  32'd1);
      checkOutput({vecs[i].name, "_pulse"},  32'(r_pulse), 32'd1);
      checkOutput({vecs[i].name, "_ready"},  32'(r_ready), 32'd1);
      checkOutput({vecs[i].name, "_held"},   32'(r_held),  32'd1);
    end

    // Flush ten cycles into a divide: no result, back to IDLE at once.
    @(negedge i_clk);
    i_valid = 1'b1; i_funct3 = 3'd5; i_op_a = 32'd100; i_op_b = 32'd7; i_tag = 5'd30;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    stray = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge i_clk);
      if (o_valid) stray++;
    end
    i_flush = 1'b1;
    @(posedge i_clk);
    #1;
    i_flush = 1'b0;
    @(negedge i_clk);
    checkOutput("flush_ready", 32'(o_ready), 32'd1);
    checkOutput("flush_busy",  32'(o_busy),  32'd0);
    for (int c = 0; c < 40; c++) begin
      @(negedge i_clk);
      if (o_valid) stray++;
    end
    checkOutput("flush_no_valid", 32'(stray), 32'd0);
    applyStimulus(3'd0, 32'd3, 32'd4, 5'd31,
                  r_res, r_tag, r_lat, r_seen, r_busy, r_pulse, r_ready, r_held);
    checkOutput("post_flush_result", r_res,        32'd12);
    checkOutput("post_flush_tag",    32'(r_tag),   32'd31);
    checkOutput("post_flush_lat",    32'(r_lat),   32'd32);

    // Asynchronous reset in the middle of CALC.
    @(negedge i_clk);
    i_valid = 1'b1; i_funct3 = 3'd0; i_op_a = 32'd5; i_op_b = 32'd6; i_tag = 5'd2;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    repeat (5) @(negedge i_clk);
    checkOutput("pre_reset_busy", 32'(o_busy), 32'd1);
    i_rst_n = 1'b0;
    #1;
    checkOutput("midreset_valid",  32'(o_valid), 32'd0);
    checkOutput("midreset_ready",  32'(o_ready), 32'd1);
    checkOutput("midreset_busy",   32'(o_busy),  32'd0);
    checkOutput("midreset_result", o_result,     32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge i_clk);
      if (o_valid) stray++;
    end
    checkOutput("midreset_no_valid", 32'(stray), 32'd0);
    applyStimulus(3'd7, 32'd100, 32'd7, 5'd1,
                  r_res, r_tag, r_lat, r_seen, r_busy, r_pulse, r_ready, r_held);
    checkOutput("post_reset_result", r_res, 32'd2);

    // Streaming with i_valid held high: every op, in tag order.
    for (int k = 0; k < 8; k++) begin
      s_f3[k] = 3'(k);
      s_a[k]  = $urandom;
      s_b[k]  = (k == 5) ? 32'($urandom_range(1, 1000)) : $urandom;
    end
    @(negedge i_clk);
    i_valid = 1'b1; i_funct3 = s_f3[0]; i_op_a = s_a[0]; i_op_b = s_b[0]; i_tag = 5'd0;
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("stream_ready_%0d", k), 32'(o_ready), 32'd1);
      @(posedge i_clk);
      #1;
      if (k < 7) begin
        i_funct3 = s_f3[k+1]; i_op_a = s_a[k+1]; i_op_b = s_b[k+1]; i_tag = 5'(k + 1);
      end else begin
        i_valid = 1'b0;
      end
      r_seen = 1'b0;
      r_busy = 1'b0;
      for (int c = 0; c < 40 && !r_seen; c++) begin
        @(negedge i_clk);
        if (c == 0) r_busy = ~o_ready;
        if (o_valid) begin
          r_seen = 1'b1;
          r_res  = o_result;
          r_tag  = o_tag;
        end
      end
      checkOutput($sformatf("stream_accepted_%0d", k), 32'(r_busy), 32'd1);
      checkOutput($sformatf("stream_seen_%0d", k),     32'(r_seen), 32'd1);
      checkOutput($sformatf("stream_tag_%0d", k),      32'(r_tag),  32'(k));
      checkOutput($sformatf("stream_result_%0d", k),   r_res,
                  golden(s_f3[k], s_a[k], s_b[k]));
      @(negedge i_clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
